// File: rtl/arith_share_arbiter_if.sv
// Request/response bus between NREQ requesters and the shared add/sub arbiter.
interface arith_share_arbiter_if #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sel;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_flag;
  logic [IDW-1:0]        rsp_id;

  // Requester/consumer side of the bus
  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flag, rsp_id
  );

  // Arbiter side of the bus
  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flag, rsp_id
  );
endinterface

// File: rtl/arith_share_arbiter.sv
// Round-robin arbiter time-sharing a single WIDTH-bit add/subtract unit among
// NREQ requesters. One operation in flight at a time: accept, execute, respond.
module arith_share_arbiter #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  arith_share_arbiter_if.slave bus,
  output logic                 busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             opSel_q, opSel_d;
  logic [WIDTH-1:0] rspData_q, rspData_d;
  logic             rspFlag_q, rspFlag_d;
  logic [IDW-1:0]   rspId_q, rspId_d;

  logic [IDW-1:0]   winner;
  logic             found;
  logic [WIDTH:0]   sum;
  int               idx;

  // Rotating priority search starting just after the last granted requester
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(lastGrant_q) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  // Offer ready only to the winner, only while idle and out of reset
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && found && !rst_i) begin
      bus.req_ready[winner] = 1'b1;
    end
  end

  // Sequencing: capture operands on accept, evaluate in EXEC, hold result in RESP
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    opSel_d     = opSel_q;
    rspData_d   = rspData_q;
    rspFlag_d   = rspFlag_q;
    rspId_d     = rspId_q;
    sum         = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          opA_d       = bus.req_a[winner*WIDTH +: WIDTH];
          opB_d       = bus.req_b[winner*WIDTH +: WIDTH];
          opSel_d     = bus.req_sel[winner];
          lastGrant_d = winner;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        // One extra bit gives carry on add and borrow (a<b) on subtract
        sum       = opSel_q ? ({1'b0, opA_q} - {1'b0, opB_q})
                            : ({1'b0, opA_q} + {1'b0, opB_q});
        rspData_d = sum[WIDTH-1:0];
        rspFlag_d = sum[WIDTH];
        rspId_d   = lastGrant_q;
        state_d   = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation and gives requester 0 first priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lastGrant_q <= IDW'(NREQ - 1);
      opA_q       <= '0;
      opB_q       <= '0;
      opSel_q     <= 1'b0;
      rspData_q   <= '0;
      rspFlag_q   <= 1'b0;
      rspId_q     <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      opSel_q     <= opSel_d;
      rspData_q   <= rspData_d;
      rspFlag_q   <= rspFlag_d;
      rspId_q     <= rspId_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rspData_q;
  assign bus.rsp_flag  = rspFlag_q;
  assign bus.rsp_id    = rspId_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_arith_share_arbiter.sv
// Scoreboard bench for arith_share_arbiter: a transaction-level model predicts
// grants and results; a separate monitor checks every presented response.
module tb_arith_share_arbiter;

  localparam int WIDTH = 5;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);

  logic clk_i = 1'b0;
  logic rst_i;
  logic busy_o;

  arith_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  arith_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus),
    .busy_o (busy_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  typedef struct {
    int data;
    int flag;
    int id;
  } rsp_t;

  rsp_t sb[$];
  int   idLog[$];
  int   checks = 0;
  int   errors = 0;

  bit   pendValid[NREQ];
  int   pendA[NREQ];
  int   pendB[NREQ];
  bit   pendSel[NREQ];
  bit   rspReadyTb;
  bit   rstTb;
  bit   rstPrev;
  int   mPhase;     // 0 waiting for a request, 1 computing, 2 presenting result
  int   lastGrant;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Expected response from plain integer arithmetic
  function automatic rsp_t model(input int w);
    rsp_t r;
    int   a = pendA[w];
    int   b = pendB[w];
    if (pendSel[w]) begin
      r.data = (a - b + (1 << WIDTH)) % (1 << WIDTH);
      r.flag = (a < b) ? 1 : 0;
    end else begin
      r.data = (a + b) % (1 << WIDTH);
      r.flag = ((a + b) >= (1 << WIDTH)) ? 1 : 0;
    end
    r.id = w;
    return r;
  endfunction

  task automatic setReq(input int i, input int a, input int b, input bit sel);
    pendValid[i] = 1'b1;
    pendA[i]     = a;
    pendB[i]     = b;
    pendSel[i]   = sel;
  endtask

  task automatic newReq(input int i);
    setReq(i, int'($urandom_range(0, (1 << WIDTH) - 1)),
              int'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 1)));
  endtask

  // One clock: drive requests, check handshake-side outputs, advance the model
  task automatic applyStimulus();
    int              w;
    int              idx;
    logic [NREQ-1:0] expReady;
    bit              accept;
    bit              respDone;
    rst_i         = rstTb;
    bus.rsp_ready = rspReadyTb;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]                = pendValid[i];
      bus.req_a[i*WIDTH +: WIDTH]     = WIDTH'(pendA[i]);
      bus.req_b[i*WIDTH +: WIDTH]     = WIDTH'(pendB[i]);
      bus.req_sel[i]                  = pendSel[i];
    end
    @(negedge clk_i);
    w = -1;
    if (mPhase == 0 && !rstTb) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (lastGrant + k) % NREQ;
        if (w < 0 && pendValid[idx]) w = idx;
      end
    end
    expReady = '0;
    if (w >= 0) expReady[w] = 1'b1;
    checkOutput("req_ready", int'(bus.req_ready), int'(expReady));
    checkOutput("rsp_valid", int'(bus.rsp_valid), (mPhase == 2) ? 1 : 0);
    checkOutput("busy", int'(busy_o), (mPhase != 0) ? 1 : 0);
    if (rstPrev) begin
      checkOutput("reset rsp_data", int'(bus.rsp_data), 0);
      checkOutput("reset rsp_flag", int'(bus.rsp_flag), 0);
      checkOutput("reset rsp_id", int'(bus.rsp_id), 0);
    end
    accept = (w >= 0);
    if (accept) sb.push_back(model(w));
    respDone = (mPhase == 2) && rspReadyTb;
    @(posedge clk_i);
    rstPrev = rstTb;
    if (rstTb) begin
      mPhase    = 0;
      lastGrant = NREQ - 1;
      sb.delete();
    end else if (accept) begin
      mPhase       = 1;
      lastGrant    = w;
      pendValid[w] = 1'b0;
    end else if (mPhase == 1) begin
      mPhase = 2;
    end else if (respDone) begin
      mPhase = 0;
    end
    #1;
  endtask

  // Monitor: whenever a response is presented it must match the oldest expectation
  always @(negedge clk_i) begin
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_valid with nothing outstanding", int'(bus.rsp_valid), 0);
      end else begin
        checkOutput("rsp_data", int'(bus.rsp_data), sb[0].data);
        checkOutput("rsp_flag", int'(bus.rsp_flag), sb[0].flag);
        checkOutput("rsp_id", int'(bus.rsp_id), sb[0].id);
        if (bus.rsp_ready) begin
          idLog.push_back(int'(bus.rsp_id));
          void'(sb.pop_front());
        end
      end
    end
  end

  // Directed scenarios followed by a randomized soak
  initial begin
    int rrExp[6];
    int acceptedId;
    rrExp = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) setReq(i, 0, 0, 1'b0);
    for (int i = 0; i < NREQ; i++) pendValid[i] = 1'b0;
    rspReadyTb    = 1'b1;
    rstTb         = 1'b1;
    rstPrev       = 1'b0;
    mPhase        = 0;
    lastGrant     = NREQ - 1;
    rst_i         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rstPrev = 1'b1;

    $display("[TB] reset with all requesters valid");
    for (int i = 0; i < NREQ; i++) newReq(i);
    rstTb = 1'b1;
    repeat (2) applyStimulus();
    rstTb = 1'b0;

    $display("[TB] round-robin with continuous requests");
    idLog.delete();
    for (int c = 0; c < 24; c++) begin
      applyStimulus();
      for (int i = 0; i < NREQ; i++) if (!pendValid[i]) newReq(i);
    end
    checkOutput("round-robin response count >= 6", (idLog.size() >= 6) ? 1 : 0, 1);
    for (int n = 0; n < 6; n++) begin
      if (n < idLog.size()) checkOutput($sformatf("round-robin id[%0d]", n), idLog[n], rrExp[n]);
    end
    for (int i = 0; i < NREQ; i++) pendValid[i] = 1'b0;
    repeat (6) applyStimulus();

    $display("[TB] add with carry and subtract with/without borrow");
    setReq(2, 20, 15, 1'b0);
    repeat (6) applyStimulus();
    setReq(1, 3, 5, 1'b1);
    repeat (6) applyStimulus();
    setReq(1, 9, 4, 1'b1);
    repeat (6) applyStimulus();
    setReq(0, 31, 31, 1'b0);
    repeat (6) applyStimulus();
    setReq(3, 0, 31, 1'b1);
    repeat (6) applyStimulus();

    $display("[TB] response backpressure");
    newReq(0);
    newReq(3);
    rspReadyTb = 1'b0;
    repeat (8) applyStimulus();
    rspReadyTb = 1'b1;
    repeat (8) applyStimulus();

    $display("[TB] reset during execution");
    setReq(1, 7, 2, 1'b0);
    setReq(3, 4, 4, 1'b1);
    for (int c = 0; c < 10 && mPhase != 1; c++) applyStimulus();
    checkOutput("mid-op accept reached", (mPhase == 1) ? 1 : 0, 1);
    acceptedId = lastGrant;
    rstTb = 1'b1;
    applyStimulus();
    rstTb = 1'b0;
    pendValid[acceptedId] = 1'b1;
    idLog.delete();
    repeat (10) applyStimulus();
    checkOutput("post-reset response count >= 1", (idLog.size() >= 1) ? 1 : 0, 1);
    if (idLog.size() >= 1) checkOutput("post-reset first id", idLog[0], 1);
    for (int i = 0; i < NREQ; i++) pendValid[i] = 1'b0;
    repeat (6) applyStimulus();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pendValid[i] && $urandom_range(0, 2) == 0) newReq(i);
        else if (pendValid[i] && $urandom_range(0, 15) == 0) pendValid[i] = 1'b0;
      end
      rspReadyTb = ($urandom_range(0, 3) != 0);
      rstTb      = ($urandom_range(0, 99) == 0);
      applyStimulus();
    end
    rstTb      = 1'b0;
    rspReadyTb = 1'b1;
    for (int i = 0; i < NREQ; i++) pendValid[i] = 1'b0;
    repeat (6) applyStimulus();
    checkOutput("scoreboard drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_share_arbiter.md
# arith_share_arbiter

Round-robin arbiter that time-shares one WIDTH-bit add/subtract unit among NREQ requesters. Each requester presents operands and an op select over a valid/ready handshake. The block grants one requester, evaluates the operation on registered operands, and returns the result, a carry/borrow flag and the requester ID over a response valid/ready handshake. It sits in front of the shared arithmetic datapath in MY_DESIGN-class designs, so duplicate adders are not needed.

## Interface
- WIDTH, 5, operand/result width
- NREQ, 4, number of requesters (≥2)
- IDW, $clog2(NREQ), requester ID width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*WIDTH  operand a; requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand b, same packing
- req_sel  in  NREQ  op select: 0 = a+b, 1 = a−b
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer accept
- rsp_data  out  WIDTH  result modulo 2^WIDTH
- rsp_flag  out  1  add: carry out; sub: borrow (a<b unsigned)
- rsp_id  out  IDW  index of the served requester
- busy  out  1  high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Winner = first i with req_valid[i]=1, searched from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On handshake: capture a, b, sel and the ID into operand registers, set last_grant=winner, go to EXEC.
  - No valid requests: stay in IDLE, req_ready all 0.
- **EXEC (one cycle):**
  - The shared add/sub evaluates the captured operands.
  - rsp_data, rsp_flag and rsp_id are registered.
  - Go to RESP.
- **RESP:**
  - rsp_valid=1; rsp_data, rsp_flag and rsp_id are held stable.
  - On rsp_valid&rsp_ready: go to IDLE.
  - rsp_ready low: stay in RESP indefinitely.
- **Arithmetic:**
  - add: {flag,data} = a + b, computed at WIDTH+1 bits.
  - sub: data = (a − b) mod 2^WIDTH; flag = (a < b) unsigned.
- **Requester rules:**
  - A requester holds req_valid and its operands stable until req_ready.
  - The arbiter never accepts while EXEC or RESP; req_ready is all 0 in those states.
  - A requester deasserting valid before grant is legal; it is skipped in arbitration.
- **Fairness:** with all requesters continuously valid, grants cycle 0,1,…,NREQ−1,0,… and no starvation is possible.

## Timing
- **Reset (rst high at a clk edge):**
  - State = IDLE; last_grant = NREQ−1, so requester 0 has first priority.
  - rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_id=0, busy=0.
  - req_ready forced to 0 while rst is high.
- **Latency:** request handshake at edge t → rsp_valid high after edge t+1 (visible in cycle t+2).
- **Throughput:** minimum 3 cycles per operation (accept, EXEC, RESP with rsp_ready=1).
  - The next grant is issued in the IDLE cycle after the response handshake.
  - Accept and respond never overlap.
- **Reset mid-operation:** rst in EXEC or RESP aborts the operation with no response; the FSM returns to IDLE with the reset values above.
- **Simultaneous events:** a requester raising valid in the same cycle that another is granted is only considered at the next IDLE cycle.

## Test plan
- **Reset:** hold rst 2 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, busy=0. First grant after release goes to requester 0.
- **Add with carry:** requester 2 sends a=20, b=15, sel=0 alone. Accept at t, then rsp_valid at t+2 with rsp_data=3, rsp_flag=1, rsp_id=2.
- **Subtract with borrow:** requester 1 sends a=3, b=5, sel=1 → rsp_data=30, rsp_flag=1, rsp_id=1. Also a=9, b=4, sel=1 → rsp_data=5, rsp_flag=0.
- **Round-robin:** all 4 requesters continuously valid with rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1. Exactly one req_ready per accept, and 3 cycles between accepts.
- **Backpressure:** hold rsp_ready=0 for 5 cycles while in RESP → rsp_valid/data/id stable, busy=1, req_ready=0. On rsp_ready=1, return to IDLE and grant the next requester.
- **Reset mid-op:** assert rst in the EXEC cycle → no rsp_valid pulse. After release, the pending requester is re-granted with priority starting at requester 0.
